food_placer: RTL
================

Name: food_placer

Overview:
Places a new food item on the snake playfield. On request it samples the free-running random grid coordinate generator and checks the candidate against every snake body segment in the segment memory. On collision it resamples, up to a retry limit, then publishes the food position to the renderer and game logic. It sits between the game FSM (request/done), the random grid generator (rand_x/rand_y) and the snake segment RAM (read port).

Parameters:
MAX_LEN, 64, maximum snake segments held in segment RAM
ADDR_W, 6, segment RAM address width (clog2 of MAX_LEN)
MAX_TRIES, 16, candidate samples per request before giving up
INIT_X, 500, food x pixel coordinate after reset
INIT_Y, 300, food y pixel coordinate after reset

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
place_req  in  1  request new food; sampled only when busy=0
rand_x  in  12  random candidate x pixel from the grid generator
rand_y  in  11  random candidate y pixel from the grid generator
snake_len  in  ADDR_W+1  number of valid segments, 0..MAX_LEN
seg_addr  out  ADDR_W  segment RAM read address, registered
seg_x  in  12  segment x; RAM has synchronous read, data valid the cycle after seg_addr
seg_y  in  11  segment y; same timing as seg_x
busy  out  1  placement in progress
food_x  out  12  current food x
food_y  out  11  current food y
food_valid  out  1  food_x/food_y hold a committed position
done  out  1  one-cycle pulse: new position committed
fail  out  1  one-cycle pulse: MAX_TRIES exhausted, old position kept
tries  out  5  candidates used by the last/current request

Behaviour:
- Reset (async, reset_n=0): state IDLE; food_x=INIT_X, food_y=INIT_Y, food_valid=1; busy=0, done=0, fail=0, seg_addr=0, tries=0. Reset mid-placement aborts immediately with no done/fail.
- States: IDLE, SAMPLE, SCAN, COMMIT, FAIL.
- IDLE: place_req=1 -> SAMPLE; busy<=1, food_valid<=0, tries<=0. place_req while busy=1 is ignored, not queued.
- SAMPLE (1 cycle): cand_x<=rand_x, cand_y<=rand_y; len_q<=min(snake_len, MAX_LEN); tries<=tries+1; seg_addr<=0 -> SCAN. If len_q=0, go -> COMMIT directly.
- SCAN: seg_addr increments by 1 per cycle up to len_q-1, then holds. Each cycle compares the returned seg_x/seg_y (for the address issued the previous cycle) with cand. A match requires both x and y equal.
  - Match and tries<MAX_TRIES -> SAMPLE (retry).
  - Match and tries=MAX_TRIES -> FAIL.
  - Compare of index len_q-1 with no match -> COMMIT.
- COMMIT (1 cycle): food_x/food_y<=cand; food_valid<=1, done<=1 for this cycle only, busy<=0 -> IDLE.
- FAIL (1 cycle): food_x/food_y unchanged; food_valid<=1, fail<=1 for one cycle, busy<=0 -> IDLE.
- Latency, no collision, len L>=1: done is high in the cycle L+3 edges after the edge that sampled place_req. A collision at index k adds k+3 edges before the next candidate's scan completes. With len=0, done comes 2 edges after acceptance.
- snake_len is sampled only in SAMPLE; changes during SCAN are ignored.
- done and fail are never high together. done/fail pulse cycles coincide with busy=0. place_req may be accepted the edge right after a done/fail pulse.
- Candidate coordinates are used unmodified; range clamping is the generator's responsibility. Comparisons are full-width, with no wrap-around.

Test Plan:
- Reset -> food_x=500, food_y=300, food_valid=1, busy=0, done=0, fail=0.
- snake_len=3, segments (250,250),(275,250),(300,250), rand=(600,400), place_req pulse -> done exactly 6 edges later, food=(600,400), tries=1, seg_addr sequence 0,1,2.
- Same snake, rand=(275,250) on first SAMPLE then (700,125) -> one retry, done with food=(700,125), tries=2.
- rand held at (250,250) (matches segment 0), MAX_TRIES=16 -> fail pulse after 16 samples, food unchanged, done never asserted, tries=16.
- snake_len=0, place_req -> done 2 edges after acceptance, food=rand; snake_len=70 -> scan stops at seg_addr=63.
- place_req pulsed again while busy -> ignored, single done; assert reset_n low mid-SCAN -> outputs return to reset values immediately, no done/fail.

Source files
------------

// File: rtl/food_placer.sv
// Food placement engine: draws a random grid candidate, scans every snake segment
// for an exact overlap and retries on collision until a free cell or MAX_TRIES.
module food_placer #(
    parameter int MAX_LEN   = 64,
    parameter int ADDR_W    = 6,
    parameter int MAX_TRIES = 16,
    parameter int INIT_X    = 500,
    parameter int INIT_Y    = 300
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              place_req,
    input  logic [11:0]       rand_x,
    input  logic [10:0]       rand_y,
    input  logic [ADDR_W:0]   snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [11:0]       seg_x,
    input  logic [10:0]       seg_y,
    output logic              busy,
    output logic [11:0]       food_x,
    output logic [10:0]       food_y,
    output logic              food_valid,
    output logic              done,
    output logic              fail,
    output logic [4:0]        tries
);

    typedef enum logic [2:0] {IDLE, SAMPLE, SCAN, COMMIT, FAIL} state_t;

    localparam logic [ADDR_W:0] LEN_CAP = (ADDR_W+1)'(MAX_LEN);
    localparam logic [4:0]      TRY_CAP = 5'(MAX_TRIES);

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
        return (len > LEN_CAP) ? LEN_CAP : len;
    endfunction

    state_t            state;
    logic [11:0]       cand_x;
    logic [10:0]       cand_y;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_now;
    logic [ADDR_W:0]   last_idx;
    logic [ADDR_W-1:0] rd_idx_p1;
    logic              vld_p1;
    logic              hit;
    logic              at_last;

    assign len_now  = clamp_len(snake_len);
    assign last_idx = len_q - (ADDR_W+1)'(1);

    // Stage p1: RAM data now on seg_x/seg_y belongs to rd_idx_p1 when vld_p1 is set
    assign hit     = vld_p1 && (seg_x == cand_x) && (seg_y == cand_y);
    assign at_last = vld_p1 && ({1'b0, rd_idx_p1} == last_idx);

    // Candidate is pure data; it is only meaningful after a SAMPLE cycle.
    always_ff @(posedge clock) begin
        if (state == SAMPLE) begin
            cand_x <= rand_x;
            cand_y <= rand_y;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            food_x     <= 12'(INIT_X);
            food_y     <= 11'(INIT_Y);
            food_valid <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            seg_addr   <= '0;
            tries      <= '0;
            len_q      <= '0;
            rd_idx_p1  <= '0;
            vld_p1     <= 1'b0;
        end else begin
            done      <= 1'b0;
            fail      <= 1'b0;
            rd_idx_p1 <= seg_addr;
            vld_p1    <= (state == SCAN);
            case (state)
                IDLE: begin
                    if (place_req) begin
                        state      <= SAMPLE;
                        busy       <= 1'b1;
                        food_valid <= 1'b0;
                        tries      <= '0;
                    end
                end
                SAMPLE: begin
                    len_q    <= len_now;
                    tries    <= tries + 5'd1;
                    seg_addr <= '0;
                    state    <= (len_now == '0) ? COMMIT : SCAN;
                end
                SCAN: begin
                    // Address runs ahead of the compare by one cycle and parks on the last segment.
                    if ({1'b0, seg_addr} < last_idx) begin
                        seg_addr <= seg_addr + ADDR_W'(1);
                    end
                    if (hit) begin
                        state <= (tries >= TRY_CAP) ? FAIL : SAMPLE;
                    end else if (at_last) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    food_x     <= cand_x;
                    food_y     <= cand_y;
                    food_valid <= 1'b1;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                FAIL: begin
                    food_valid <= 1'b1;
                    fail       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
